// File: rtl/aes_gcm_block_collector.sv
// aes_gcm_block_collector
//   Receive side of the AES-GCM counter/phase scheduler. NUM_WORKERS parallel
//   AES workers hand back processed blocks tagged with their block counter and
//   a 3-bit phase. Blocks are parked in a DEPTH-slot reorder buffer indexed by
//   counter mod DEPTH and released in strict counter order as one stream with
//   first/last/AAD flags. The scheduler's byte reversal is undone on the way in.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        pulse: start (or abort and restart) an instance
//   i_valid/o_ready, i_counter, i_phase, i_block
//                  per-worker handshake and tagged block (worker w in slice w)
//   o_valid/i_ready, o_block, o_counter, o_first, o_last, o_aad
//                  in-order output stream, natural byte order
//   o_done         one-cycle pulse after the last block was handed off
//   o_busy         instance running or output still pending
//   o_err          sticky duplicate-counter flag, cleared by i_start
module aes_gcm_block_collector #(
  parameter int NUM_WORKERS = 2,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [NUM_WORKERS-1:0]       i_valid,
  input  logic [NUM_WORKERS*CNT_W-1:0] i_counter,
  input  logic [NUM_WORKERS*3-1:0]     i_phase,
  input  logic [NUM_WORKERS*128-1:0]   i_block,
  output logic [NUM_WORKERS-1:0]       o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [127:0]                 o_block,
  output logic [CNT_W-1:0]             o_counter,
  output logic                         o_first,
  output logic                         o_last,
  output logic                         o_aad,
  output logic                         o_done,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] PH_FIRST   = 3'b000;
  localparam logic [2:0] PH_AAD     = 3'b010;
  localparam logic [2:0] PH_LAST    = 3'b011;
  localparam logic [2:0] PH_INVALID = 3'b100;
  localparam logic [2:0] PH_ONLY    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte n of the result is byte 15-n of the argument.
  function automatic logic [127:0] byte_rev(input logic [127:0] blk);
    logic [127:0] res;
    res = 128'd0;
    for (int n = 0; n < 16; n++) begin
      res[8*n +: 8] = blk[8*(15-n) +: 8];
    end
    return res;
  endfunction

  function automatic logic ph_is_first(input logic [2:0] ph);
    return (ph == PH_FIRST) || (ph == PH_ONLY);
  endfunction

  function automatic logic ph_is_last(input logic [2:0] ph);
    return (ph == PH_LAST) || (ph == PH_ONLY);
  endfunction

  state_t                 state_r, state_n;
  logic [CNT_W-1:0]       expect_r;
  logic [DEPTH-1:0]       slot_vld_r;
  logic [CNT_W-1:0]       slot_cnt_r [DEPTH];
  logic [2:0]             slot_ph_r  [DEPTH];
  logic [127:0]           slot_blk_r [DEPTH];

  logic                   ov_r, ov_n;
  logic [127:0]           oblk_r;
  logic [CNT_W-1:0]       ocnt_r;
  logic                   ofirst_r, olast_r, oaad_r;
  logic                   done_r, busy_r, err_r;

  logic [CNT_W-1:0]       cnt_s  [NUM_WORKERS];
  logic [2:0]             ph_s   [NUM_WORKERS];
  logic [IDX_W-1:0]       idx_s  [NUM_WORKERS];
  logic [CNT_W-1:0]       diff_s [NUM_WORKERS];
  logic [NUM_WORKERS-1:0] in_win_s, slot_hit_s, slot_free_s;
  logic [NUM_WORKERS-1:0] ready_s, wr_s, dup_s, lower_hit_s;

  logic [IDX_W-1:0]       head_idx_s;
  logic                   head_hit_s, last_out_s, load_s;

  // Per-worker decode: slot index, window test and slot occupancy.
  for (genvar w = 0; w < NUM_WORKERS; w++) begin : g_dec
    assign cnt_s[w]       = i_counter[w*CNT_W +: CNT_W];
    assign ph_s[w]        = i_phase[w*3 +: 3];
    assign idx_s[w]       = cnt_s[w][IDX_W-1:0];
    assign diff_s[w]      = cnt_s[w] - expect_r;
    // Counters never wrap inside an instance, so a plain compare is enough.
    assign in_win_s[w]    = (cnt_s[w] >= expect_r) && (diff_s[w] < CNT_W'(DEPTH));
    assign slot_hit_s[w]  = slot_vld_r[idx_s[w]] && (slot_cnt_r[idx_s[w]] == cnt_s[w]);
    assign slot_free_s[w] = !slot_vld_r[idx_s[w]];
  end

  assign head_idx_s = expect_r[IDX_W-1:0];
  assign head_hit_s = slot_vld_r[head_idx_s] && (slot_cnt_r[head_idx_s] == expect_r);
  assign last_out_s = ov_r && i_ready && olast_r;

  // Worker acceptance: invalid-phase drops, duplicate drops and slot writes.
  always_comb begin
    ready_s     = '0;
    wr_s        = '0;
    dup_s       = '0;
    lower_hit_s = '0;
    for (int w = 0; w < NUM_WORKERS; w++) begin
      // A lower-indexed worker already writing this counter wins the tie.
      for (int v = 0; v < w; v++) begin
        if (wr_s[v] && (cnt_s[v] == cnt_s[w])) begin
          lower_hit_s[w] = 1'b1;
        end else begin
          lower_hit_s[w] = lower_hit_s[w];
        end
      end
      if ((state_r != ST_RUN) || i_start) begin
        ready_s[w] = 1'b0;
      end else if (ph_s[w] == PH_INVALID) begin
        ready_s[w] = 1'b1;
      end else if (slot_hit_s[w] || lower_hit_s[w]) begin
        ready_s[w] = 1'b1;
        dup_s[w]   = i_valid[w];
      end else if (in_win_s[w] && slot_free_s[w]) begin
        ready_s[w] = 1'b1;
        wr_s[w]    = i_valid[w];
      end else begin
        ready_s[w] = 1'b0;
      end
    end
  end

  // Next state, output-register load decision and next o_valid.
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    ov_n    = ov_r;
    if (i_start) begin
      state_n = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: state_n = ST_IDLE;
        ST_RUN:  state_n = last_out_s ? ST_DONE : ST_RUN;
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
    // Nothing past the last block is loaded while it is being handed off.
    if (i_start) begin
      load_s = 1'b0;
    end else begin
      load_s = (state_r == ST_RUN) && !last_out_s && (!ov_r || i_ready) && head_hit_s;
    end
    if (i_start) begin
      ov_n = 1'b0;
    end else if (load_s) begin
      ov_n = 1'b1;
    end else if (i_ready) begin
      ov_n = 1'b0;
    end else begin
      ov_n = ov_r;
    end
  end

  // Control state, expected counter, output register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      expect_r <= '0;
      ov_r     <= 1'b0;
      oblk_r   <= 128'd0;
      ocnt_r   <= '0;
      ofirst_r <= 1'b0;
      olast_r  <= 1'b0;
      oaad_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      ov_r    <= ov_n;
      done_r  <= (state_n == ST_DONE);
      busy_r  <= (state_n == ST_RUN) || ov_n;
      if (i_start) begin
        expect_r <= '0;
        err_r    <= 1'b0;
      end else begin
        err_r <= err_r | (|dup_s);
        if (load_s) begin
          oblk_r   <= slot_blk_r[head_idx_s];
          ocnt_r   <= expect_r;
          ofirst_r <= ph_is_first(slot_ph_r[head_idx_s]);
          olast_r  <= ph_is_last(slot_ph_r[head_idx_s]);
          oaad_r   <= (slot_ph_r[head_idx_s] == PH_AAD);
          expect_r <= expect_r + CNT_W'(1);
        end
      end
    end
  end

  // Reorder slots: free on output load, then apply worker writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_r <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        slot_cnt_r[s] <= '0;
        slot_ph_r[s]  <= 3'd0;
        slot_blk_r[s] <= 128'd0;
      end
    end else if (i_start) begin
      slot_vld_r <= '0;
    end else begin
      if (load_s) begin
        slot_vld_r[head_idx_s] <= 1'b0;
      end
      for (int w = 0; w < NUM_WORKERS; w++) begin
        if (wr_s[w]) begin
          slot_vld_r[idx_s[w]] <= 1'b1;
          slot_cnt_r[idx_s[w]] <= cnt_s[w];
          slot_ph_r[idx_s[w]]  <= ph_s[w];
          slot_blk_r[idx_s[w]] <= byte_rev(i_block[w*128 +: 128]);
        end
      end
    end
  end

  assign o_ready   = ready_s;
  assign o_valid   = ov_r;
  assign o_block   = oblk_r;
  assign o_counter = ocnt_r;
  assign o_first   = ofirst_r;
  assign o_last    = olast_r;
  assign o_aad     = oaad_r;
  assign o_done    = done_r;
  assign o_busy    = busy_r;
  assign o_err     = err_r;

endmodule
